// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier monitors: default widths, run FSM states
// and a saturating adder.
package approx_mult_pkg;

    localparam int unsigned PROD_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Adds a + b and clamps to the largest w-bit value (w <= 64); callers cast to their width.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Combinational error distance between an approximate and an exact product: d = |approx - exact|
// and ne = (d != 0).
module approx_err_dist
    import approx_mult_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF
) (
    input  logic [PROD_W-1:0] approx_p,
    input  logic [PROD_W-1:0] exact_p,
    output logic [PROD_W-1:0] d,
    output logic              ne
);

    logic [PROD_W:0] diff;
    logic [PROD_W:0] diff_neg;

    always_comb begin
        diff     = {1'b0, approx_p} - {1'b0, exact_p};
        diff_neg = '0 - diff;
        // The extra top bit is the borrow: set when exact_p > approx_p.
        d        = diff[PROD_W] ? diff_neg[PROD_W-1:0] : diff[PROD_W-1:0];
        ne       = |d;
    end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Error-distance statistics over a run of SAMPLES products: distance stage, accumulate stage, run FSM.
// Define APPROX_ERR_SQ_EN to add the ed_sq_sum output (saturating sum of d*d).
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned SAMPLES = 256,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] approx_p,
    input  logic [PROD_W-1:0] exact_p,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [ACC_W-1:0]  ed_sum,
`ifdef APPROX_ERR_SQ_EN
    output logic [ACC_W-1:0]  ed_sq_sum,
`endif
    output logic [PROD_W-1:0] ed_max
);

    state_e state_q, state_d;

    logic              accept;
    logic              clear;
    logic              last;
    logic [PROD_W-1:0] dist_d;
    logic              dist_ne;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0] s1_d_q, s1_d_d;
    logic              s1_ne_q, s1_ne_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [ACC_W-1:0]  ed_sum_q, ed_sum_d;
    logic [PROD_W-1:0] ed_max_q, ed_max_d;
`ifdef APPROX_ERR_SQ_EN
    logic [ACC_W-1:0]  ed_sq_sum_q, ed_sq_sum_d;
    logic [63:0]       sq;
`endif

    approx_err_dist #(
        .PROD_W (PROD_W)
    ) u_dist (
        .approx_p (approx_p),
        .exact_p  (exact_p),
        .d        (dist_d),
        .ne       (dist_ne)
    );

    assign accept = in_valid && in_ready;
    assign clear  = start && ((state_q == StIdle) || (state_q == StDone));
    assign last   = accept && (cnt_q == CNT_W'(SAMPLES - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StRun;
            StRun:          if (last) state_d = StFlush;
            StFlush:        if (!s1_valid_q) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == StRun);
        busy     = (state_q == StRun) || (state_q == StFlush);
        done     = (state_q == StDone);
    end

    // Sample counter and distance stage
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = accept;
        s1_d_d     = s1_d_q;
        s1_ne_d    = s1_ne_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept) begin
            s1_d_d  = dist_d;
            s1_ne_d = dist_ne;
        end
    end

    // Accumulate stage
    always_comb begin
        err_count_d = err_count_q;
        ed_sum_d    = ed_sum_q;
        ed_max_d    = ed_max_q;
`ifdef APPROX_ERR_SQ_EN
        sq          = 64'(s1_d_q) * 64'(s1_d_q);
        ed_sq_sum_d = ed_sq_sum_q;
`endif
        if (clear) begin
            err_count_d = '0;
            ed_sum_d    = '0;
            ed_max_d    = '0;
`ifdef APPROX_ERR_SQ_EN
            ed_sq_sum_d = '0;
`endif
        end else if (s1_valid_q) begin
            err_count_d = err_count_q + CNT_W'(s1_ne_q);
            ed_sum_d    = ACC_W'(sat_add(64'(ed_sum_q), 64'(s1_d_q), ACC_W));
            ed_max_d    = (s1_d_q > ed_max_q) ? s1_d_q : ed_max_q;
`ifdef APPROX_ERR_SQ_EN
            ed_sq_sum_d = ACC_W'(sat_add(64'(ed_sq_sum_q), sq, ACC_W));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_d_q      <= '0;
            s1_ne_q     <= 1'b0;
            err_count_q <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
`ifdef APPROX_ERR_SQ_EN
            ed_sq_sum_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_d_q      <= s1_d_d;
            s1_ne_q     <= s1_ne_d;
            err_count_q <= err_count_d;
            ed_sum_q    <= ed_sum_d;
            ed_max_q    <= ed_max_d;
`ifdef APPROX_ERR_SQ_EN
            ed_sq_sum_q <= ed_sq_sum_d;
`endif
        end
    end

    assign err_count = err_count_q;
    assign ed_sum    = ed_sum_q;
    assign ed_max    = ed_max_q;
`ifdef APPROX_ERR_SQ_EN
    assign ed_sq_sum = ed_sq_sum_q;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench: three monitor instances (SAMPLES=4; SAMPLES=3; SAMPLES=2 with ACC_W=8) share the
// sample bus and reset; each is started separately.
module tb_approx_mult_err_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] ap;
    logic [7:0] ep;
    logic       start_a, start_b, start_c;

    logic        a_ready, a_busy, a_done;
    logic [15:0] a_err;
    logic [23:0] a_sum;
    logic [7:0]  a_max;
    logic        b_ready, b_busy, b_done;
    logic [15:0] b_err;
    logic [23:0] b_sum;
    logic [7:0]  b_max;
    logic        c_ready, c_busy, c_done;
    logic [15:0] c_err;
    logic [7:0]  c_sum;
    logic [7:0]  c_max;
`ifdef APPROX_ERR_SQ_EN
    logic [23:0] a_sq;
    logic [23:0] b_sq;
    logic [7:0]  c_sq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.PROD_W(8), .SAMPLES(4), .ACC_W(24), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_ready),
        .approx_p(ap), .exact_p(ep), .busy(a_busy), .done(a_done), .err_count(a_err),
        .ed_sum(a_sum),
`ifdef APPROX_ERR_SQ_EN
        .ed_sq_sum(a_sq),
`endif
        .ed_max(a_max)
    );

    approx_mult_err_monitor #(.PROD_W(8), .SAMPLES(3), .ACC_W(24), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_ready),
        .approx_p(ap), .exact_p(ep), .busy(b_busy), .done(b_done), .err_count(b_err),
        .ed_sum(b_sum),
`ifdef APPROX_ERR_SQ_EN
        .ed_sq_sum(b_sq),
`endif
        .ed_max(b_max)
    );

    approx_mult_err_monitor #(.PROD_W(8), .SAMPLES(2), .ACC_W(8), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(c_ready),
        .approx_p(ap), .exact_p(ep), .busy(c_busy), .done(c_done), .err_count(c_err),
        .ed_sum(c_sum),
`ifdef APPROX_ERR_SQ_EN
        .ed_sq_sum(c_sq),
`endif
        .ed_max(c_max)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle (with junk data) for gap cycles, then present one sample for one cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] e, input int gap);
        in_valid = 1'b0;
        ap = 8'd255;
        ep = 8'd0;
        repeat (gap) tick();
        in_valid = 1'b1;
        ap = a;
        ep = e;
        tick();
        in_valid = 1'b0;
        ap = 8'd255;
        ep = 8'd0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        ap = 8'd0;
        ep = 8'd0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;

        // Reset and idle
        tick();
        tick();
        chk("rst_ready", b_ready, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_done", b_done, 0);
        chk("rst_err", b_err, 0);
        chk("rst_sum", b_sum, 0);
        chk("rst_max", b_max, 0);
        rst = 1'b0;
        ap = 8'd255;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("idle_ready", b_ready, 0);
        chk("idle_err", b_err, 0);
        chk("idle_sum", b_sum, 0);
        chk("idle_max", b_max, 0);
        chk("idle_a_sum", a_sum, 0);

        // Exact run, SAMPLES=4
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("ex_ready_run", a_ready, 1);
        chk("ex_busy_run", a_busy, 1);
        send(8'd6, 8'd6, 0);
        send(8'd0, 8'd0, 0);
        send(8'd15, 8'd15, 0);
        send(8'd225, 8'd225, 0);
        chk("ex_ready_flush", a_ready, 0);
        chk("ex_busy_flush", a_busy, 1);
        chk("ex_done_t1", a_done, 0);
        tick();
        chk("ex_done_t2", a_done, 0);
        tick();
        chk("ex_done_t3", a_done, 1);
        chk("ex_busy_done", a_busy, 0);
        chk("ex_err", a_err, 0);
        chk("ex_sum", a_sum, 0);
        chk("ex_max", a_max, 0);

        // Error run, SAMPLES=3, back-to-back
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        send(8'd20, 8'd36, 0);
        chk("er_err_t1", b_err, 0);
        send(8'd48, 8'd48, 0);
        chk("er_err_t2", b_err, 1);
        chk("er_sum_t2", b_sum, 16);
        chk("er_max_t2", b_max, 16);
        send(8'd64, 8'd40, 0);
        chk("er_ready_flush", b_ready, 0);
        chk("er_sum_t3", b_sum, 16);
        tick();
        chk("er_err", b_err, 2);
        chk("er_sum", b_sum, 40);
        chk("er_max", b_max, 24);
        chk("er_done_t2", b_done, 0);
        tick();
        chk("er_done_t3", b_done, 1);
`ifdef APPROX_ERR_SQ_EN
        chk("er_sq", b_sq, 832);
`endif

        // Restart from DONE, with bubbles and an ignored start mid-run
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("rs_done_drop", b_done, 0);
        chk("rs_err_clr", b_err, 0);
        chk("rs_sum_clr", b_sum, 0);
        chk("rs_max_clr", b_max, 0);
        chk("rs_busy", b_busy, 1);
        send(8'd20, 8'd36, 2);
        start_b = 1'b1;
        send(8'd48, 8'd48, 0);
        start_b = 1'b0;
        send(8'd64, 8'd40, 3);
        chk("bb_ready_drop", b_ready, 0);
        tick();
        tick();
        chk("bb_done", b_done, 1);
        chk("bb_err", b_err, 2);
        chk("bb_sum", b_sum, 40);
        chk("bb_max", b_max, 24);

        // Saturation, ACC_W=8, SAMPLES=2
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        send(8'd255, 8'd0, 0);
        send(8'd255, 8'd0, 1);
        tick();
        tick();
        chk("sat_done", c_done, 1);
        chk("sat_sum", c_sum, 255);
        chk("sat_max", c_max, 255);
        chk("sat_err", c_err, 2);
`ifdef APPROX_ERR_SQ_EN
        chk("sat_sq", c_sq, 255);
`endif

        // Mid-run reset
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        send(8'd20, 8'd36, 0);
        tick();
        chk("mr_err_before", b_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", b_busy, 0);
        chk("mr_done", b_done, 0);
        chk("mr_ready", b_ready, 0);
        chk("mr_err", b_err, 0);
        chk("mr_sum", b_sum, 0);
        chk("mr_c_done", c_done, 0);
        send(8'd48, 8'd48, 0);
        send(8'd64, 8'd40, 0);
        tick();
        tick();
        tick();
        chk("mr_no_done", b_done, 0);
        chk("mr_sum_after", b_sum, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
